// File: rtl/game_pkg.sv
// Shared types and limits for the game-flow controller and its BCD converter.
package game_pkg;

    typedef enum logic [2:0] {StLogo, StReady, StPlay, StTup, StBoard} game_state_t;

    localparam int unsigned DIGIT_W   = 5;
    localparam int unsigned SCORE_MAX = 9999;
    localparam int unsigned TIME_MAX  = 99;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one load cycle, 14 shift/add-3 cycles, then a done cycle
// during which bcd holds the finished digits for the parent to register.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        iRST_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    typedef enum logic [1:0] {CvIdle, CvShift, CvOut} cv_state_t;

    cv_state_t   state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adj;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end

        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CvIdle: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CvShift;
                end
            end
            CvShift: begin
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = CvOut;
            end
            CvOut:   state_d = CvIdle;
            default: state_d = CvIdle;
        endcase
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= CvIdle;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != CvIdle);
    assign done = (state_q == CvOut);
    assign bcd  = acc_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: screen FSM, one-second tick, round countdown and player-1 score
// with BCD digit outputs for the display.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 25_000_000,
    parameter int unsigned READY_SECS    = 3,
    parameter int unsigned ROUND_SECS    = 60,
    parameter int unsigned TIMESUP_SECS  = 3,
    parameter int unsigned TRACE_PTS     = 10,
    parameter int unsigned SNITCH_PTS    = 150,
    parameter int unsigned LIGHTNING_PEN = 50,
    parameter int unsigned TURNER_SECS   = 10
) (
    input  logic               clk,
    input  logic               iRST_n,
    input  logic               start_btn,
    input  logic               trace_done,
    input  logic               snitch_caught,
    input  logic               time_turner_caught,
    input  logic               lightning_hit,
    output logic               logo,
    output logic               get_ready,
    output logic               times_up,
    output logic               leaderboard,
    output logic               round_active,
    output logic               sec_tick,
    output logic [6:0]         time_left,
    output logic [DIGIT_W-1:0] p1_score_ones,
    output logic [DIGIT_W-1:0] p1_score_tens,
    output logic [DIGIT_W-1:0] p1_score_hundreds,
    output logic [DIGIT_W-1:0] p1_score_thousands
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [17:0] TracePts = 18'(TRACE_PTS);
    localparam logic signed [17:0] SnitchPts = 18'(SNITCH_PTS);
    localparam logic signed [17:0] LightPen = 18'(LIGHTNING_PEN);
    localparam logic signed [17:0] ScoreMax = 18'(SCORE_MAX);

    game_state_t       state_q, state_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]        phase_q, phase_d;
    logic [6:0]        time_q, time_d;
    logic [13:0]       score_q, score_d, score_next;
    logic [13:0]       last_q;
    logic [15:0]       digits_q;
    logic              start_q;
    logic              tick, start_rise;
    logic signed [17:0] score_sum;
    logic [7:0]        turner_sum;
    logic [6:0]        turner_time;
    logic              conv_start, conv_busy, conv_done;
    logic [15:0]       conv_bcd;

    assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign start_rise = start_btn & ~start_q;

    always_comb begin
        score_sum = $signed({4'd0, score_q})
                  + (trace_done    ? TracePts  : 18'sd0)
                  + (snitch_caught ? SnitchPts : 18'sd0)
                  - (lightning_hit ? LightPen  : 18'sd0);
        if (score_sum < 18'sd0)         score_next = '0;
        else if (score_sum > ScoreMax)  score_next = 14'(SCORE_MAX);
        else                            score_next = score_sum[13:0];

        // A tick in the same cycle as the turner is folded in as -1.
        turner_sum  = {1'b0, time_q} + 8'(TURNER_SECS) - {7'd0, tick};
        turner_time = (turner_sum > 8'(TIME_MAX)) ? 7'(TIME_MAX) : turner_sum[6:0];
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        time_d  = time_q;
        score_d = score_q;
        unique case (state_q)
            StLogo: if (start_rise) state_d = StReady;
            StReady: begin
                if (tick) begin
                    if (phase_q == 8'(READY_SECS - 1)) begin
                        state_d = StPlay;
                        time_d  = 7'(ROUND_SECS);
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            StPlay: begin
                score_d = score_next;
                if (time_turner_caught) begin
                    time_d = turner_time;
                end else if (tick) begin
                    time_d = time_q - 7'd1;
                    if (time_q == 7'd1) state_d = StTup;
                end
            end
            StTup: begin
                if (tick) begin
                    if (phase_q == 8'(TIMESUP_SECS - 1)) state_d = StBoard;
                    else                                 phase_d = phase_q + 8'd1;
                end
            end
            StBoard: begin
                if (start_rise) begin
                    state_d = StReady;
                    score_d = '0;
                end
            end
            default: state_d = StLogo;
        endcase

        // Restart divider and phase count on every transition so each phase runs full length.
        if (state_d != state_q) begin
            phase_d    = '0;
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        end
    end

    assign conv_start = ~conv_busy & (score_q != last_q);

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= StLogo;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            time_q     <= '0;
            score_q    <= '0;
            last_q     <= '0;
            digits_q   <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            time_q     <= time_d;
            score_q    <= score_d;
            start_q    <= start_btn;
            if (conv_start) last_q <= score_q;
            if (conv_done)  digits_q <= conv_bcd;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .iRST_n (iRST_n),
        .start  (conv_start),
        .bin    (score_q),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    assign logo         = (state_q == StLogo);
    assign get_ready    = (state_q == StReady);
    assign times_up     = (state_q == StTup);
    assign leaderboard  = (state_q == StBoard);
    assign round_active = (state_q == StPlay);
    assign sec_tick     = tick;
    assign time_left    = time_q;

    assign p1_score_ones      = {1'b0, digits_q[3:0]};
    assign p1_score_tens      = {1'b0, digits_q[7:4]};
    assign p1_score_hundreds  = {1'b0, digits_q[11:8]};
    assign p1_score_thousands = {1'b0, digits_q[15:12]};

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: phase-level reference model plus scenario tasks.
module tb_game_sequencer;

    localparam int TD = 4;
    localparam int RDY = 3;
    localparam int RND = 60;
    localparam int TUPS = 3;
    localparam int M_LOGO = 0, M_READY = 1, M_PLAY = 2, M_TUP = 3, M_BOARD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_btn = 1'b0, trace_done = 1'b0, snitch_caught = 1'b0;
    logic time_turner_caught = 1'b0, lightning_hit = 1'b0;
    logic logo, get_ready, times_up, leaderboard, round_active, sec_tick;
    logic [6:0] time_left;
    logic [4:0] d_ones, d_tens, d_hund, d_thou;
    logic [19:0] dig;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    game_sequencer #(.TICK_DIV(TD)) dut (
        .clk                (clk),
        .iRST_n             (rst_n),
        .start_btn          (start_btn),
        .trace_done         (trace_done),
        .snitch_caught      (snitch_caught),
        .time_turner_caught (time_turner_caught),
        .lightning_hit      (lightning_hit),
        .logo               (logo),
        .get_ready          (get_ready),
        .times_up           (times_up),
        .leaderboard        (leaderboard),
        .round_active       (round_active),
        .sec_tick           (sec_tick),
        .time_left          (time_left),
        .p1_score_ones      (d_ones),
        .p1_score_tens      (d_tens),
        .p1_score_hundreds  (d_hund),
        .p1_score_thousands (d_thou)
    );

    assign dig = {d_thou, d_hund, d_tens, d_ones};

    function automatic logic [19:0] dec20(input int v);
        return {1'b0, 4'(v / 1000), 1'b0, 4'((v / 100) % 10),
                1'b0, 4'((v / 10) % 10), 1'b0, 4'(v % 10)};
    endfunction

    function automatic logic [4:0] exp_flags(input int st);
        case (st)
            M_LOGO:  return 5'b10000;
            M_READY: return 5'b01000;
            M_TUP:   return 5'b00100;
            M_BOARD: return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    // Reference model: phase, cycles since phase entry, seconds left, score.
    int m_state, m_cyc, m_ticks, m_time, m_score, m_stable;
    bit m_prev;
    logic m_tick;
    int n_state, n_time, n_score, n_ticks;
    bit rise_v;

    assign m_tick = (m_cyc % TD) == TD - 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= M_LOGO; m_cyc <= 0; m_ticks <= 0; m_time <= 0;
            m_score <= 0; m_stable <= 100; m_prev <= 1'b0;
        end else begin
            rise_v  = start_btn && !m_prev;
            n_state = m_state; n_time = m_time; n_score = m_score;
            n_ticks = m_ticks + (m_tick ? 1 : 0);
            case (m_state)
                M_LOGO: if (rise_v) n_state = M_READY;
                M_READY: if (m_tick && n_ticks == RDY) begin
                    n_state = M_PLAY;
                    n_time = RND;
                end
                M_PLAY: begin
                    n_score = m_score + 10 * int'(trace_done) + 150 * int'(snitch_caught)
                              - 50 * int'(lightning_hit);
                    if (n_score < 0) n_score = 0;
                    if (n_score > 9999) n_score = 9999;
                    if (time_turner_caught) begin
                        n_time = m_time + 10 - (m_tick ? 1 : 0);
                        if (n_time > 99) n_time = 99;
                    end else if (m_tick) begin
                        n_time = m_time - 1;
                        if (n_time == 0) n_state = M_TUP;
                    end
                end
                M_TUP: if (m_tick && n_ticks == TUPS) n_state = M_BOARD;
                M_BOARD: if (rise_v) begin
                    n_state = M_READY;
                    n_score = 0;
                end
                default: n_state = M_LOGO;
            endcase
            m_prev   <= start_btn;
            m_cyc    <= (n_state != m_state) ? 0 : m_cyc + 1;
            m_ticks  <= (n_state != m_state) ? 0 : n_ticks;
            m_stable <= (n_score != m_score) ? 0 : ((m_stable < 1000) ? m_stable + 1 : m_stable);
            m_state  <= n_state;
            m_time   <= n_time;
            m_score  <= n_score;
        end
    end

    // Continuous cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            checks++;
            if ({logo, get_ready, times_up, leaderboard, round_active} !== exp_flags(m_state)) begin
                failures++;
                $display("FAIL flags t=%0t: got %b want %b", $time,
                         {logo, get_ready, times_up, leaderboard, round_active},
                         exp_flags(m_state));
            end
            checks++;
            if (sec_tick !== m_tick) begin
                failures++;
                $display("FAIL sec_tick t=%0t: got %b want %b", $time, sec_tick, m_tick);
            end
            checks++;
            if (time_left !== 7'(m_time)) begin
                failures++;
                $display("FAIL time_left t=%0t: got %0d want %0d", $time, time_left, m_time);
            end
            if (m_stable >= 34) begin
                checks++;
                if (dig !== dec20(m_score)) begin
                    failures++;
                    $display("FAIL digits t=%0t: got %h want %h", $time, dig, dec20(m_score));
                end
            end
        end
    end

    task automatic clear_inputs;
        trace_done = 0; snitch_caught = 0; lightning_hit = 0; time_turner_caught = 0;
    endtask

    task automatic rand_events;
        trace_done    = ($urandom_range(5) == 0);
        snitch_caught = ($urandom_range(11) == 0);
        lightning_hit = ($urandom_range(7) == 0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({logo, get_ready, times_up, leaderboard, round_active} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 10000",
                     {logo, get_ready, times_up, leaderboard, round_active});
        end
        checks++;
        if (time_left !== 7'd0 || sec_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_time: got %0d/%b want 0/0", time_left, sec_tick);
        end
        checks++;
        if (dig !== 20'h0) begin
            failures++;
            $display("FAIL reset_digits: got %h want 00000", dig);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start;
        int cnt;
        repeat (5) @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        checks++;
        if (get_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_to_ready: got %b want 1", get_ready);
        end
        cnt = 1;
        // Hold start, and fire events, while READY: all must be ignored.
        for (int i = 0; i < 100 && get_ready; i++) begin
            start_btn = (i < 2);
            trace_done = (i == 2);
            snitch_caught = (i == 4);
            time_turner_caught = (i == 5);
            @(negedge clk);
            if (get_ready) cnt++;
        end
        start_btn = 0;
        clear_inputs();
        checks++;
        if (round_active !== 1'b1 || cnt != RDY * TD) begin
            failures++;
            $display("FAIL ready_len: got active=%b cycles=%0d want 1/%0d",
                     round_active, cnt, RDY * TD);
        end
        checks++;
        if (time_left !== 7'd60) begin
            failures++;
            $display("FAIL play_load: got %0d want 60", time_left);
        end
    endtask

    task automatic test_scoring;
        bit hit;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) trace_done = 1; else snitch_caught = 1;
            @(negedge clk);
            clear_inputs();
            @(negedge clk);
        end
        hit = 0;
        for (int i = 0; i < 33 && !hit; i++) begin
            @(negedge clk);
            hit = (dig === dec20(180));
        end
        checks++;
        if (dig !== dec20(180)) begin
            failures++;
            $display("FAIL score_180: got %h want %h", dig, dec20(180));
        end
        repeat (20) @(negedge clk);
        lightning_hit = 1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            lightning_hit = 0;
            if (i == 8 || i == 16) begin
                checks++;
                if (dig !== dec20(180)) begin
                    failures++;
                    $display("FAIL digits_midconv cyc=%0d: got %h want %h", i, dig, dec20(180));
                end
            end
            if (i == 17) begin
                checks++;
                if (dig !== dec20(130)) begin
                    failures++;
                    $display("FAIL score_130_lat17: got %h want %h", dig, dec20(130));
                end
            end
        end
    endtask

    task automatic test_time_turner_95;
        bit fired = 0;
        for (int i = 0; i < 3000 && !fired; i++) begin
            rand_events();
            if (m_time == 95 && m_tick) begin
                time_turner_caught = 1;
                fired = 1;
            end else begin
                time_turner_caught = (m_time < 95 && !m_tick);
            end
            @(negedge clk);
        end
        clear_inputs();
        checks++;
        if (!fired || time_left !== 7'd99) begin
            failures++;
            $display("FAIL turner_95_on_tick: got fired=%b time=%0d want 1/99", fired, time_left);
        end
    endtask

    task automatic test_score_saturation;
        for (int i = 0; i < 500 && m_score < 9990; i++) begin
            snitch_caught = (m_score + 150 <= 9990);
            trace_done = !snitch_caught;
            time_turner_caught = (m_time < 90);
            @(negedge clk);
        end
        clear_inputs();
        repeat (40) @(negedge clk);
        trace_done = 1;
        @(negedge clk);
        trace_done = 0;
        repeat (34) @(negedge clk);
        checks++;
        if (dig !== dec20(9999)) begin
            failures++;
            $display("FAIL score_sat_high: got %h want %h", dig, dec20(9999));
        end
        for (int i = 0; i < 500 && m_score > 0; i++) begin
            lightning_hit = 1;
            time_turner_caught = (m_time < 90);
            @(negedge clk);
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            trace_done = 1;
            @(negedge clk);
            trace_done = 0;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (dig !== dec20(30)) begin
            failures++;
            $display("FAIL score_30: got %h want %h", dig, dec20(30));
        end
        lightning_hit = 1;
        @(negedge clk);
        lightning_hit = 0;
        repeat (34) @(negedge clk);
        checks++;
        if (dig !== dec20(0)) begin
            failures++;
            $display("FAIL score_sat_low: got %h want %h", dig, dec20(0));
        end
    endtask

    task automatic test_turner_last_second;
        bit fired = 0;
        for (int i = 0; i < 3000 && !fired; i++) begin
            rand_events();
            start_btn = $urandom_range(1);
            if (m_time == 1 && m_tick) begin
                time_turner_caught = 1;
                fired = 1;
            end
            @(negedge clk);
        end
        clear_inputs();
        start_btn = 0;
        checks++;
        if (!fired || time_left !== 7'd10 || round_active !== 1'b1) begin
            failures++;
            $display("FAIL turner_last_sec: got fired=%b time=%0d active=%b want 1/10/1",
                     fired, time_left, round_active);
        end
    endtask

    task automatic test_round_end;
        logic [6:0] prev_t;
        int cnt;
        prev_t = 7'h7f;
        for (int i = 0; i < 200 && !times_up; i++) begin
            prev_t = time_left;
            @(negedge clk);
        end
        checks++;
        if (times_up !== 1'b1 || prev_t !== 7'd1 || time_left !== 7'd0) begin
            failures++;
            $display("FAIL round_end: got tup=%b prev=%0d time=%0d want 1/1/0",
                     times_up, prev_t, time_left);
        end
        cnt = 0;
        for (int i = 0; i < 100 && !leaderboard; i++) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (leaderboard !== 1'b1 || cnt != TUPS * TD) begin
            failures++;
            $display("FAIL tup_len: got board=%b cycles=%0d want 1/%0d",
                     leaderboard, cnt, TUPS * TD);
        end
    endtask

    task automatic test_gating_board;
        int base;
        base = m_score;
        for (int i = 0; i < 8; i++) begin
            trace_done = 1;
            snitch_caught = i[0];
            lightning_hit = (i == 3);
            time_turner_caught = (i == 5);
            @(negedge clk);
        end
        clear_inputs();
        repeat (40) @(negedge clk);
        checks++;
        if (dig !== dec20(base) || time_left !== 7'd0 || leaderboard !== 1'b1) begin
            failures++;
            $display("FAIL board_gating: got %h/%0d/%b want %h/0/1",
                     dig, time_left, leaderboard, dec20(base));
        end
        start_btn = 1;
        @(negedge clk);
        start_btn = 0;
        checks++;
        if (get_ready !== 1'b1) begin
            failures++;
            $display("FAIL board_restart: got ready=%b want 1", get_ready);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (dig !== 20'h0) begin
            failures++;
            $display("FAIL board_clear: got %h want 00000", dig);
        end
    endtask

    task automatic test_reset_mid;
        snitch_caught = 1;
        @(negedge clk);
        snitch_caught = 0;
        repeat (40) @(negedge clk);
        trace_done = 1;
        @(negedge clk);
        trace_done = 0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dig !== 20'h0 || logo !== 1'b1 || round_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got dig=%h logo=%b active=%b want 00000/1/0",
                     dig, logo, round_active);
        end
        checks++;
        if (time_left !== 7'd0 || sec_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_time: got %0d/%b want 0/0", time_left, sec_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (dig !== 20'h0 || logo !== 1'b1) begin
            failures++;
            $display("FAIL reset_abandon: got dig=%h logo=%b want 00000/1", dig, logo);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_scoring();
        test_time_turner_95();
        test_score_saturation();
        test_turner_last_second();
        test_round_end();
        test_gating_board();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
